// File: rtl/edge_delay_meter.sv
// edge_delay_meter: measures stim-edge to resp-edge delay in clk cycles,
// with min/max/count statistics.
module edge_delay_meter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stim,
    input  logic             resp,
    input  logic             clr,
    output logic [CNT_W-1:0] delay,
    output logic             delay_vld,
    output logic             timeout,
    output logic             overrun,
    output logic             busy,
    output logic [CNT_W-1:0] min_delay,
    output logic [CNT_W-1:0] max_delay,
    output logic [15:0]      meas_cnt
);

    localparam logic IDLE = 1'b0;
    localparam logic WAIT = 1'b1;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [SYNC_STAGES-1:0] s_sync;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   s_q;
    logic                   r_q;
    logic                   se;
    logic                   re;
    logic                   state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_p1;
    logic                   hit;
    logic [CNT_W-1:0]       hv;
    logic [CNT_W-1:0]       base_min;
    logic [CNT_W-1:0]       base_max;
    logic [15:0]            base_cnt;

    // Equal-depth chains keep stim and resp latency identical.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_sync <= '0;
            r_sync <= '0;
            s_q    <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            s_sync <= {s_sync[SYNC_STAGES-2:0], stim};
            r_sync <= {r_sync[SYNC_STAGES-2:0], resp};
            s_q    <= s_sync[SYNC_STAGES-1];
            r_q    <= r_sync[SYNC_STAGES-1];
        end
    end

    assign se     = s_sync[SYNC_STAGES-1] ^ s_q;
    assign re     = r_sync[SYNC_STAGES-1] ^ r_q;
    assign cnt_p1 = cnt + 1'b1;
    assign busy   = (state == WAIT);

    always_comb begin
        hit = 1'b0;
        hv  = '0;
        if (state == IDLE && se && re) begin
            hit = 1'b1;
        end else if (state == WAIT && re) begin
            hit = 1'b1;
            hv  = cnt_p1;
        end
    end

    // A clear in the sample cycle acts first, then the sample folds in.
    assign base_min = clr ? CMAX : min_delay;
    assign base_max = clr ? '0 : max_delay;
    assign base_cnt = clr ? 16'd0 : meas_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_delay <= CMAX;
            max_delay <= '0;
            meas_cnt  <= 16'd0;
        end else begin
            min_delay <= (hit && hv < base_min) ? hv : base_min;
            max_delay <= (hit && hv > base_max) ? hv : base_max;
            if (hit && base_cnt != 16'hFFFF)
                meas_cnt <= base_cnt + 16'd1;
            else
                meas_cnt <= base_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            delay     <= '0;
            delay_vld <= 1'b0;
            timeout   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            delay_vld <= hit;
            timeout   <= 1'b0;
            overrun   <= 1'b0;
            if (hit)
                delay <= hv;
            case (state)
                IDLE: begin
                    if (se && !re) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (re) begin
                        cnt <= '0;
                        if (!se)
                            state <= IDLE;
                    end else if (se) begin
                        overrun <= 1'b1;
                        cnt     <= '0;
                    end else if (cnt_p1 == CMAX) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt_p1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_delay_meter.sv
// tb_edge_delay_meter: directed checks of delay, statistics, overrun,
// timeout and reset behaviour.
module tb_edge_delay_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stim = 1'b0, resp = 1'b0, clr = 1'b0;
    logic        stim_b = 1'b0, resp_b = 1'b0, clr_b = 1'b0;
    logic [7:0]  delay, min_delay, max_delay;
    logic        delay_vld, timeout, overrun, busy;
    logic [15:0] meas_cnt;
    logic [3:0]  delay_b, min_b, max_b;
    logic        vld_b, to_b, ov_b, busy_b;
    logic [15:0] meas_b;

    int checks = 0;
    int errors = 0;
    int n_vld = 0, n_to = 0, n_ov = 0, n_busy = 0;
    int nb_vld = 0, nb_to = 0, nb_ov = 0, nb_busy = 0;
    int v0, t0, o0, b0;

    always #5 clk = ~clk;

    edge_delay_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .stim(stim), .resp(resp), .clr(clr),
        .delay(delay), .delay_vld(delay_vld), .timeout(timeout),
        .overrun(overrun), .busy(busy), .min_delay(min_delay),
        .max_delay(max_delay), .meas_cnt(meas_cnt)
    );

    edge_delay_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .stim(stim_b), .resp(resp_b), .clr(clr_b),
        .delay(delay_b), .delay_vld(vld_b), .timeout(to_b),
        .overrun(ov_b), .busy(busy_b), .min_delay(min_b),
        .max_delay(max_b), .meas_cnt(meas_b)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            n_vld   <= n_vld + int'(delay_vld);
            n_to    <= n_to + int'(timeout);
            n_ov    <= n_ov + int'(overrun);
            n_busy  <= n_busy + int'(busy);
            nb_vld  <= nb_vld + int'(vld_b);
            nb_to   <= nb_to + int'(to_b);
            nb_ov   <= nb_ov + int'(ov_b);
            nb_busy <= nb_busy + int'(busy_b);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        v0 = n_vld;
        t0 = n_to;
        o0 = n_ov;
        b0 = n_busy;
    endtask

    initial begin
        cyc(3);
        check("rst_delay", delay, 0);
        check("rst_min", min_delay, 255);
        check("rst_max", max_delay, 0);
        check("rst_cnt", meas_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_vld", delay_vld, 0);
        rst_n = 1'b1;
        cyc(2);

        // clean measurement, delay 4
        snap();
        stim = 1'b1;
        cyc(4);
        resp = 1'b1;
        cyc(8);
        check("clean_delay", delay, 4);
        check("clean_vld", n_vld - v0, 1);
        check("clean_min", min_delay, 4);
        check("clean_max", max_delay, 4);
        check("clean_cnt", meas_cnt, 1);

        // statistics: 6, 2, 9 after a clear
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        stim = 1'b0;
        cyc(6);
        resp = 1'b0;
        cyc(8);
        stim = 1'b1;
        cyc(2);
        resp = 1'b1;
        cyc(8);
        stim = 1'b0;
        cyc(9);
        resp = 1'b0;
        cyc(12);
        check("stat_delay", delay, 9);
        check("stat_min", min_delay, 2);
        check("stat_max", max_delay, 9);
        check("stat_cnt", meas_cnt, 3);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(1);
        check("clr_min", min_delay, 255);
        check("clr_max", max_delay, 0);
        check("clr_cnt", meas_cnt, 0);
        check("clr_delay", delay, 9);

        // zero delay
        snap();
        stim = 1'b1;
        resp = 1'b1;
        cyc(8);
        check("zero_delay", delay, 0);
        check("zero_vld", n_vld - v0, 1);
        check("zero_busy", n_busy - b0, 0);
        check("zero_min", min_delay, 0);
        check("zero_cnt", meas_cnt, 1);
        stim = 1'b0;
        resp = 1'b0;
        cyc(8);

        // overrun: 2-cycle stim pulse, resp 5 after falling edge
        snap();
        stim = 1'b1;
        cyc(2);
        stim = 1'b0;
        cyc(5);
        resp = 1'b1;
        cyc(8);
        check("ovr_pulses", n_ov - o0, 1);
        check("ovr_delay", delay, 5);
        check("ovr_vld", n_vld - v0, 1);
        check("ovr_busy", busy, 0);

        // clear coinciding with the sample: delay 3
        stim = 1'b1;
        cyc(3);
        resp = 1'b0;
        cyc(2);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(6);
        check("clrvld_delay", delay, 3);
        check("clrvld_min", min_delay, 3);
        check("clrvld_max", max_delay, 3);
        check("clrvld_cnt", meas_cnt, 1);

        // timeout on the 4-bit instance
        stim_b = 1'b1;
        cyc(30);
        check("to_pulses", nb_to, 1);
        check("to_vld", nb_vld, 0);
        check("to_busycyc", nb_busy, 15);
        check("to_busy", busy_b, 0);
        check("to_delay", delay_b, 0);
        resp_b = 1'b1;
        cyc(8);
        check("idle_re_vld", nb_vld, 0);
        check("idle_re_to", nb_to, 1);
        check("idle_re_ov", nb_ov, 0);
        check("idle_re_busy", nb_busy, 15);

        // reset mid-measurement
        snap();
        stim = 1'b0;
        cyc(6);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_delay", delay, 0);
        check("mid_rst_min", min_delay, 255);
        check("mid_rst_max", max_delay, 0);
        check("mid_rst_cnt", meas_cnt, 0);
        check("mid_rst_vld", delay_vld, 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        resp = 1'b1;
        cyc(8);
        check("post_vld", n_vld - v0, 0);
        check("post_busy", busy, 0);
        check("post_to", n_to - t0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
